// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver for the sc1 serial input: 16x oversampling, 3-sample majority vote,
// and a small byte FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 40_000_000,
  parameter int SCLK_HZ    = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rxd,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [FIFO_DEPTH:0]   rx_count,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int DIV     = CLK_HZ / (SCLK_HZ * 16);
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ENTRIES = 1 << FIFO_DEPTH;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_ONE  = DIV_W'(1);
  localparam logic [FIFO_DEPTH-1:0] PTR_ONE  = FIFO_DEPTH'(1);
  localparam logic [FIFO_DEPTH:0]   CNT_ONE  = (FIFO_DEPTH + 1)'(1);
  localparam logic [FIFO_DEPTH:0]   CNT_FULL = (FIFO_DEPTH + 1)'(ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and start-edge detection
  // ---------------------------------------------------------------------------
  logic       rxd_meta;
  logic       rxd_sync;
  logic       rxd_prev;
  logic [1:0] sync_vld;
  logic       armed;
  logic       start_edge;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      sync_vld <= {sync_vld[0], 1'b1};
      // The synchronizer resets to idle-high, so a line already low at release would
      // otherwise look like a falling edge; edges count only after a real high is seen.
      if (sync_vld[1] && rxd_sync) armed <= 1'b1;
    end
  end

  assign start_edge = armed && rxd_prev && !rxd_sync;

  // ---------------------------------------------------------------------------
  // Oversampling tick, sub-bit counter and majority vote
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       sub_cnt;
  logic [2:0]       bit_idx;
  logic             samp7;
  logic             samp8;
  logic [7:0]       shreg;
  logic             tick;
  logic             decide;
  logic             bit_end;
  logic             vote;
  logic             clear_cnt;
  logic             shift_en;
  logic             push_d;
  logic             push_q;
  logic             ferr_d;

  assign tick    = (div_cnt == DIV_LAST);
  assign decide  = tick && (sub_cnt == 4'd9);
  assign bit_end = tick && (sub_cnt == 4'd15);
  assign vote    = (samp7 & samp8) | (samp7 & rxd_sync) | (samp8 & rxd_sync);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sub_cnt <= '0;
      bit_idx <= '0;
      samp7   <= 1'b1;
      samp8   <= 1'b1;
    end else if (clear_cnt) begin
      div_cnt <= '0;
      sub_cnt <= '0;
      bit_idx <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
      if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        if (sub_cnt == 4'd7) samp7 <= rxd_sync;
        if (sub_cnt == 4'd8) samp8 <= rxd_sync;
        if (sub_cnt == 4'd15 && state_q == S_DATA) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      push_q    <= push_d;
      frame_err <= ferr_d;
      if (shift_en) shreg <= {vote, shreg[7:1]};
    end
  end

  // NOTE: every output of this block gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    shift_en  = 1'b0;
    push_d    = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_START;
          clear_cnt = 1'b1;
        end
      end
      S_START: begin
        if (decide && vote)  state_d = S_IDLE;
        else if (bit_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) shift_en = 1'b1;
        if (bit_end && bit_idx == 3'd7) state_d = S_STOP;
      end
      S_STOP: begin
        // Leaving mid-stop-bit lets the next start edge be caught without delay.
        if (decide) begin
          if (vote) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxd_sync) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO with registered head
  // ---------------------------------------------------------------------------
  logic [7:0]            mem [ENTRIES];
  logic [FIFO_DEPTH-1:0] wr_ptr;
  logic [FIFO_DEPTH-1:0] rd_ptr;
  logic [FIFO_DEPTH-1:0] rd_next;
  logic [FIFO_DEPTH:0]   count;
  logic                  pop;
  logic                  full;
  logic                  wr_en;

  assign rx_valid = (count != '0);
  assign rx_count = count;
  assign pop      = rx_valid && rx_ready;
  assign full     = (count == CNT_FULL);
  assign wr_en    = push_q && (!full || pop);
  assign rd_next  = rd_ptr + PTR_ONE;

  // NOTE: storage has no reset; entries are only read once the occupancy count says
  // they were written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push_q && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_next;
      unique case ({wr_en, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // rx_data only moves on a pop or when a byte lands in an empty FIFO.
      if (pop) begin
        if (count > CNT_ONE) rx_data <= mem[rd_next];
        else if (wr_en)      rx_data <= shreg;
      end else if (wr_en && count == '0) begin
        rx_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a frame table plus hand-timed sequences for glitch,
// overflow, full-FIFO push/pop collision and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  // 115200 baud from a 14.7456 MHz clock gives an exact divider of 8.
  localparam int  CLK_HZ      = 14_745_600;
  localparam int  SCLK_HZ     = 115_200;
  localparam int  FIFO_DEPTH  = 4;
  localparam int  DIV         = CLK_HZ / (SCLK_HZ * 16);
  localparam int  BIT_CLKS    = 16 * DIV;
  localparam int  GLITCH_CLKS = 7;
  localparam real CLK_HALF    = 1.0e9 / (2.0 * CLK_HZ);
  // Start edge to push cycle: 2 sync flops + 1 edge-detect register, then the
  // tick-9 decision of the stop bit (tick 154 counting from 1), then 1 cycle to push.
  localparam int  PUSH_OFS    = 3 + (9 * 16 + 10) * DIV;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                uart_rxd = 1'b1;
  logic                rx_ready = 1'b0;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [FIFO_DEPTH:0] rx_count;
  logic                frame_err;
  logic                overflow;

  uart_rx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .SCLK_HZ   (SCLK_HZ),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_count (rx_count),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #(CLK_HALF) clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         extra_low;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  int         ferr_cnt;
  int         ovf_cnt;
  int         vld_cycles;
  bit         track_min = 1'b0;
  int         min_cnt;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) vld_cycles++;
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (track_min && int'(rx_count) < min_cnt) min_cnt = int'(rx_count);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    ferr_cnt   = 0;
    ovf_cnt    = 0;
    vld_cycles = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int extra_low);
    uart_rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      wait_clks(BIT_CLKS);
    end
    uart_rxd = stop;
    wait_clks(BIT_CLKS);
    if (extra_low > 0) begin
      uart_rxd = 1'b0;
      wait_clks(extra_low * BIT_CLKS);
    end
    uart_rxd = 1'b1;
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hDEAD;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, extra_low: 0, exp_bytes: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b1, extra_low: 0, exp_bytes: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'h3C, stop: 1'b0, extra_low: 3, exp_bytes: 0, exp_ferr: 1};
    vecs[3] = '{data: 8'h81, stop: 1'b1, extra_low: 0, exp_bytes: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, extra_low: 0, exp_bytes: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, extra_low: 0, exp_bytes: 1, exp_ferr: 0};

    clear_mon();
    wait_clks(3);
    check("rst_rx_data",   32'(rx_data),   32'h0);
    check("rst_rx_valid",  32'(rx_valid),  32'h0);
    check("rst_rx_count",  32'(rx_count),  32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    reset_n = 1'b1;
    wait_clks(10);

    // Frame table, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].extra_low);
      wait_clks(2 * BIT_CLKS);
      check($sformatf("vec%0d_bytes", i),      32'(rx_q.size()), 32'(vecs[i].exp_bytes));
      check($sformatf("vec%0d_vld_cycles", i), 32'(vld_cycles),  32'(vecs[i].exp_bytes));
      if (vecs[i].exp_bytes > 0)
        check($sformatf("vec%0d_data", i), q_at(0), 32'(vecs[i].data));
      check($sformatf("vec%0d_frame_err", i), 32'(ferr_cnt), 32'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_overflow", i),  32'(ovf_cnt),  32'h0);
      check($sformatf("vec%0d_rx_count", i),  32'(rx_count), 32'h0);
    end

    // Short low glitch on an idle line, then a normal frame.
    clear_mon();
    uart_rxd = 1'b0;
    wait_clks(GLITCH_CLKS);
    uart_rxd = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_bytes",     32'(rx_q.size()), 32'h0);
    check("glitch_frame_err", 32'(ferr_cnt),    32'h0);
    check("glitch_rx_valid",  32'(rx_valid),    32'h0);
    send_frame(8'hC5, 1'b1, 0);
    wait_clks(2 * BIT_CLKS);
    check("post_glitch_bytes", 32'(rx_q.size()), 32'h1);
    check("post_glitch_data",  q_at(0),          32'hC5);

    // Fill with rx_ready low; the 17th byte overflows.
    rx_ready = 1'b0;
    clear_mon();
    for (int b = 0; b < 17; b++) begin
      send_frame(8'(b), 1'b1, 0);
      wait_clks(BIT_CLKS);
      if (b == 15) begin
        check("fill16_rx_count", 32'(rx_count), 32'd16);
        check("fill16_overflow", 32'(ovf_cnt),  32'h0);
      end
    end
    check("ovf_pulses",   32'(ovf_cnt),     32'h1);
    check("ovf_rx_count", 32'(rx_count),    32'd16);
    check("ovf_rx_valid", 32'(rx_valid),    32'h1);
    check("ovf_head",     32'(rx_data),     32'h00);
    check("ovf_no_pops",  32'(rx_q.size()), 32'h0);

    // Full FIFO: a single-cycle pop lands on the push cycle of 0x77.
    clear_mon();
    min_cnt   = 99;
    track_min = 1'b1;
    fork
      send_frame(8'h77, 1'b1, 0);
      begin
        wait_clks(PUSH_OFS);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    wait_clks(BIT_CLKS);
    track_min = 1'b0;
    check("coll_overflow", 32'(ovf_cnt),     32'h0);
    check("coll_rx_count", 32'(rx_count),    32'd16);
    check("coll_min_cnt",  32'(min_cnt),     32'd16);
    check("coll_pops",     32'(rx_q.size()), 32'h1);
    check("coll_popped",   q_at(0),          32'h00);

    // Drain: 0x00 already popped, then 0x01..0x0F and finally 0x77.
    rx_ready = 1'b1;
    wait_clks(24);
    rx_ready = 1'b0;
    check("drain_count", 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++)
      check($sformatf("drain_%0d", i), q_at(i), (i < 16) ? 32'(i) : 32'h77);
    check("drain_rx_count", 32'(rx_count), 32'h0);
    check("drain_rx_valid", 32'(rx_valid), 32'h0);

    // Reset during data bit 4 of 0xF0, released while the line is low.
    rx_ready = 1'b1;
    clear_mon();
    uart_rxd = 1'b0;
    wait_clks(5 * BIT_CLKS);
    uart_rxd = 1'b1;
    wait_clks(BIT_CLKS / 2);
    reset_n = 1'b0;
    wait_clks(2);
    check("midrst_rx_data",   32'(rx_data),   32'h0);
    check("midrst_rx_valid",  32'(rx_valid),  32'h0);
    check("midrst_rx_count",  32'(rx_count),  32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_overflow",  32'(overflow),  32'h0);
    uart_rxd = 1'b0;
    wait_clks(BIT_CLKS);
    reset_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    uart_rxd = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("postrst_bytes",     32'(rx_q.size()), 32'h0);
    check("postrst_frame_err", 32'(ferr_cnt),    32'h0);
    check("postrst_rx_valid",  32'(rx_valid),    32'h0);
    clear_mon();
    send_frame(8'h5A, 1'b1, 0);
    wait_clks(2 * BIT_CLKS);
    check("clean_bytes",    32'(rx_q.size()), 32'h1);
    check("clean_data",     q_at(0),          32'h5A);
    check("clean_rx_count", 32'(rx_count),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
